// File: rtl/text_cursor_writer.sv
// text_cursor_writer: turns a valid/ready character stream into registered writes for a ROWS x COLS text RAM.
// Optional macro TEXT_AUTOWRAP_EN: a printable at the last column wraps the cursor to the next row.
module text_cursor_writer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ROWS           = 4,
    parameter int COLS           = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      char_valid,
    input  logic [DATA_WIDTH-1:0]     char_data,
    output logic                      char_ready,
    output logic                      we,
    output logic [$clog2(ROWS)-1:0]   w_row,
    output logic [$clog2(COLS)-1:0]   w_col,
    output logic [DATA_WIDTH-1:0]     din,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      busy
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [DATA_WIDTH-1:0] C_BS    = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] C_LF    = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] C_FF    = DATA_WIDTH'(8'h0C);
    localparam logic [DATA_WIDTH-1:0] C_CR    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] C_SP    = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] C_TILDE = DATA_WIDTH'(8'h7E);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    localparam state_t S_RST = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t                r_state, w_state_nx;
    logic                  r_we, w_we_nx;
    logic [RW-1:0]         r_w_row, w_w_row_nx, r_cur_row, w_cur_row_nx, r_swp_row, w_swp_row_nx;
    logic [CW-1:0]         r_w_col, w_w_col_nx, r_cur_col, w_cur_col_nx, r_swp_col, w_swp_col_nx;
    logic [DATA_WIDTH-1:0] r_din, w_din_nx;
    logic                  w_printable, w_col_last, w_row_last, w_swp_col_last, w_swp_row_last;

    assign char_ready     = (r_state == S_IDLE);
    assign busy           = (r_state == S_CLEAR);
    assign we             = r_we;
    assign w_row          = r_w_row;
    assign w_col          = r_w_col;
    assign din            = r_din;
    assign cursor_row     = r_cur_row;
    assign cursor_col     = r_cur_col;
    assign w_printable    = (char_data >= C_SP) && (char_data <= C_TILDE);
    assign w_col_last     = (r_cur_col == CW'(COLS - 1));
    assign w_row_last     = (r_cur_row == RW'(ROWS - 1));
    assign w_swp_col_last = (r_swp_col == CW'(COLS - 1));
    assign w_swp_row_last = (r_swp_row == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_we      <= 1'b0;
            r_w_row   <= '0;
            r_w_col   <= '0;
            r_din     <= '0;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_swp_row <= '0;
            r_swp_col <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_we      <= w_we_nx;
            r_w_row   <= w_w_row_nx;
            r_w_col   <= w_w_col_nx;
            r_din     <= w_din_nx;
            r_cur_row <= w_cur_row_nx;
            r_cur_col <= w_cur_col_nx;
            r_swp_row <= w_swp_row_nx;
            r_swp_col <= w_swp_col_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_we_nx      = 1'b0;
        w_w_row_nx   = r_w_row;
        w_w_col_nx   = r_w_col;
        w_din_nx     = r_din;
        w_cur_row_nx = r_cur_row;
        w_cur_col_nx = r_cur_col;
        w_swp_row_nx = r_swp_row;
        w_swp_col_nx = r_swp_col;
        if (r_state == S_CLEAR) begin
            // sweep counter returns to (0,0) after the last cell, ready for the next clear
            w_we_nx      = 1'b1;
            w_w_row_nx   = r_swp_row;
            w_w_col_nx   = r_swp_col;
            w_din_nx     = C_SP;
            w_swp_col_nx = w_swp_col_last ? '0 : r_swp_col + CW'(1);
            w_swp_row_nx = !w_swp_col_last ? r_swp_row : w_swp_row_last ? '0 : r_swp_row + RW'(1);
            w_state_nx   = (w_swp_col_last && w_swp_row_last) ? S_IDLE : S_CLEAR;
        end else if (char_valid) begin
            if (w_printable) begin
                w_we_nx    = 1'b1;
                w_w_row_nx = r_cur_row;
                w_w_col_nx = r_cur_col;
                w_din_nx   = char_data;
`ifdef TEXT_AUTOWRAP_EN
                w_cur_col_nx = w_col_last ? '0 : r_cur_col + CW'(1);
                w_cur_row_nx = !w_col_last ? r_cur_row : w_row_last ? '0 : r_cur_row + RW'(1);
`else
                w_cur_col_nx = w_col_last ? r_cur_col : r_cur_col + CW'(1);
`endif
            end else if (char_data == C_LF) begin
                w_cur_col_nx = '0;
                w_cur_row_nx = w_row_last ? '0 : r_cur_row + RW'(1);
            end else if (char_data == C_CR) begin
                w_cur_col_nx = '0;
            end else if (char_data == C_BS && (r_cur_col != '0 || r_cur_row != '0)) begin
                w_cur_col_nx = (r_cur_col != '0) ? r_cur_col - CW'(1) : CW'(COLS - 1);
                w_cur_row_nx = (r_cur_col != '0) ? r_cur_row : r_cur_row - RW'(1);
                w_we_nx      = 1'b1;
                w_w_row_nx   = w_cur_row_nx;
                w_w_col_nx   = w_cur_col_nx;
                w_din_nx     = C_SP;
            end else if (char_data == C_FF) begin
                w_state_nx   = S_CLEAR;
                w_cur_row_nx = '0;
                w_cur_col_nx = '0;
            end
        end
    end
endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Upstream producer for the character-cell dual-port RAM (ROWS x COLS cells of DATA_WIDTH bits).
- Accepts a stream of 8-bit character codes over a valid/ready handshake.
- Maintains a text cursor and interprets control codes (LF, CR, BS, FF).
- Drives the RAM write port (we, w_row, w_col, din) with registered outputs, including a full-screen clear sweep.

Parameters:
- DATA_WIDTH, 8, width of char_data and din.
- ROWS, 4, text rows; must match RAM; >=2.
- COLS, 32, text columns; must match RAM; >=2.
- CLEAR_ON_RESET, 1, 1 = run a clear sweep immediately after reset release.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- char_valid  in  1  char_data is valid.
- char_data  in  DATA_WIDTH  character code.
- char_ready  out  1  block can accept a character this cycle.
- we  out  1  RAM write enable (registered).
- w_row  out  $clog2(ROWS)  RAM write row (registered).
- w_col  out  $clog2(COLS)  RAM write column (registered).
- din  out  DATA_WIDTH  RAM write data (registered).
- cursor_row  out  $clog2(ROWS)  current cursor row.
- cursor_col  out  $clog2(COLS)  current cursor column.
- busy  out  1  clear sweep in progress.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assert, active-low; release is sampled on clk.
- Reset values:
  - we=0, w_row=0, w_col=0, din=0, cursor=(0,0).
  - State CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy=1 if CLEAR_ON_RESET=1, else 0.
- char_ready = (state==IDLE); combinational from state. busy = (state==CLEAR).
- Accept occurs when char_valid && char_ready at a rising edge. Throughput is one character per cycle in IDLE.
- States:
  - IDLE: accepts characters.
  - CLEAR: sweep counter runs 0..ROWS*COLS-1.
- Any cycle with no accept and no sweep: we=0 at the next edge; w_row/w_col/din hold their values.
- Printable character (0x20..0x7E) accepted:
  - Next edge: we=1, w_row/w_col = cursor before the advance, din=char_data.
  - Cursor advances at the same edge. Write latency is 1 cycle from accept.
- Advance rule (col==COLS-1): see Optional Feature. Otherwise col+1.
- LF (0x0A): no write. Cursor goes to (row+1, 0); row ROWS-1 wraps to row 0.
- CR (0x0D): no write. Cursor goes to (row, 0).
- BS (0x08):
  - Cursor moves back one cell: col>0 gives (row, col-1); col==0 && row>0 gives (row-1, COLS-1).
  - A space (0x20) is written at the new position with the same 1-cycle latency.
  - At (0,0): consumed, no write, no move.
- FF (0x0C): consumed, no write; enter CLEAR at the next edge.
- Any other code: consumed, ignored; we=0.
- CLEAR:
  - Exactly ROWS*COLS consecutive cycles with we=1, din=0x20.
  - Addresses are row-major: (0,0),(0,1)..(ROWS-1,COLS-1).
  - char_ready=0 throughout. cursor=(0,0) on entry.
  - After the last write the next state is IDLE; we=0 on the following edge.
- Reset asserted mid-sweep or mid-write: all outputs return to reset values immediately; no partial state is retained.
- Counters are unsigned and sized to exactly $clog2 of the bound. Wrap is done by explicit compare, not by overflow, so ROWS/COLS that are not powers of 2 work.

Optional Feature:
- Macro: TEXT_AUTOWRAP_EN.
- Defined: a printable character at col COLS-1 advances the cursor to (row+1, 0); row ROWS-1 wraps to (0,0).
- Undefined: the cursor stays at col COLS-1. Further printables overwrite cell (row, COLS-1) until LF/CR/BS/FF.

Test Plan:
- Release reset, CLEAR_ON_RESET=1, 4x32 -> busy=1 and 128 consecutive we pulses, din=0x20, addresses (0,0)..(3,31) in order; then char_ready=1, busy=0, cursor (0,0).
- In IDLE, drive 0x41 then 0x42 back-to-back -> we at (0,0)=0x41 then (0,1)=0x42 on consecutive cycles; cursor (0,2); char_ready stays 1.
- Cursor at (3,0), send 33 x 0x58 with TEXT_AUTOWRAP_EN -> 33rd write at (0,0), cursor (0,1); without the macro -> writes 32 and 33 both at (3,31), cursor stays (3,31).
- Cursor (2,5): LF -> cursor (3,0), no we; LF -> cursor (0,0); then CR at (0,7) -> cursor (0,0), no we.
- Cursor (1,0): BS -> we at (0,31) din=0x20, cursor (0,31); cursor (0,0): BS -> no we, cursor unchanged; code 0x07 -> no we.
- Send 0x0C with char_valid held high -> char_ready=0 for 128 cycles; assert rst_n low at sweep cycle 40 -> we=0, outputs at reset values at once; after release the sweep restarts from (0,0).
